cpuc_xbar_core: RTL and testbench

- Parametrised successor to the CPUc crossbar datapath.
- Registers, operator units and constants are linked by an encoded (not one-hot) per-cycle crossbar instruction read from an internal program RAM.
- Program and constant stores load through write ports; start/done run control, PC auto-increment, input-stall handshake and output-valid handshake.
- Sits between the test/host loader and downstream consumers of out1/out2.

---
 rtl/cpuc_xbar_core.sv | 203 ++++++++++++++++++++
 tb/tb_cpuc_xbar_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuc_xbar_core.sv
// cpuc_xbar_core: crossbar datapath driven by an encoded per-cycle instruction
// from an internal program RAM. Registers, operator units, constants and the
// external input are all crossbar sources; each register may load one source
// per instruction. Register PC_IDX doubles as the program counter.
// Optional feature macro: CPUC_PERF_EN adds run/stall cycle counters.
module cpuc_xbar_core #(
    parameter int W          = 16,
    parameter int NREG       = 4,
    parameter int NPLUS      = 1,
    parameter int NMINUS     = 1,
    parameter int NMUL       = 1,
    parameter int NLES       = 1,
    parameter int NEQU       = 1,
    parameter int NCONST     = 4,
    parameter int PROG_DEPTH = 64,
    parameter int PC_IDX     = 0,
    parameter int OUT_IDX    = 3,
    localparam int NOP    = NPLUS + NMINUS + NMUL + NLES + NEQU,
    localparam int NSRC   = NREG + NOP + NCONST + 1,
    localparam int SW     = $clog2(NSRC),
    localparam int IW     = 1 + NREG * (SW + 1) + 2 * NOP * SW,
    localparam int PW     = $clog2(PROG_DEPTH),
    localparam int CW     = (NCONST > 1) ? $clog2(NCONST) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [PW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          const_we,
    input  logic [CW-1:0] const_addr,
    input  logic [W-1:0]  const_data,
    input  logic          start,
    input  logic [PW-1:0] start_pc,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out1,
    output logic [W-1:0]  out2,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] pc
`ifdef CPUC_PERF_EN
    ,
    output logic [31:0]   run_cycles,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int OPBASE = 1 + NREG * (SW + 1);
    localparam int P_END  = NPLUS;
    localparam int M_END  = P_END + NMINUS;
    localparam int MU_END = M_END + NMUL;
    localparam int L_END  = MU_END + NLES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state;
    logic [NREG-1:0][W-1:0]         regs;
    logic [NCONST-1:0][W-1:0]       consts;
    logic [IW-1:0]                  prog_ram [PROG_DEPTH];

    logic [IW-1:0]                  instr;
    logic [PW-1:0]                  pc_cur;
    logic [PW-1:0]                  pc_next;
    logic                           halt;
    logic [NREG-1:0]                reg_we;
    logic [NREG-1:0][SW-1:0]        reg_sel;
    logic [2*NOP-1:0][SW-1:0]       op_sel;
    logic [NOP-1:0][W-1:0]          op_res;
    logic [NREG-1:0][W-1:0]         reg_val;
    logic                           needs_in;
    logic                           stall;

    // Crossbar source mux; an operator only sees operator results below 'limit',
    // which is what keeps operator chains free of combinational loops.
    function automatic logic [W-1:0] src_pick(
        input logic [SW-1:0]            sel,
        input int                       limit,
        input logic [NREG-1:0][W-1:0]   rv,
        input logic [NOP-1:0][W-1:0]    ov,
        input logic [NCONST-1:0][W-1:0] cv,
        input logic [W-1:0]             iv
    );
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++)
            if (sel == SW'(r)) v = rv[r];
        for (int j = 0; j < NOP; j++)
            if (j < limit && sel == SW'(NREG + j)) v = ov[j];
        for (int c = 0; c < NCONST; c++)
            if (sel == SW'(NREG + NOP + c)) v = cv[c];
        if (sel == SW'(NSRC - 1)) v = iv;
        return v;
    endfunction

    assign pc_cur    = regs[PC_IDX][PW-1:0];
    assign pc        = pc_cur;
    assign out1      = regs[1];
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign instr     = prog_ram[pc_cur];
    assign stall     = needs_in && !in_valid;
    assign in_ready  = (state == RUN) && needs_in;

    // Split the current instruction into its fields and detect input use
    always_comb begin
        halt     = instr[0];
        needs_in = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            reg_sel[r] = instr[1 + r * (SW + 1) +: SW];
            reg_we[r]  = instr[1 + r * (SW + 1) + SW];
            if (reg_we[r] && reg_sel[r] == SW'(NSRC - 1)) needs_in = 1'b1;
        end
        for (int k = 0; k < 2 * NOP; k++) begin
            op_sel[k] = instr[OPBASE + k * SW +: SW];
            if (op_sel[k] == SW'(NSRC - 1)) needs_in = 1'b1;
        end
    end

    // Evaluate operator units in index order so lower units can feed higher ones
    always_comb begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        op_res = '0;
        for (int i = 0; i < NOP; i++) begin
            a = src_pick(op_sel[2*i],     i, regs, op_res, consts, in_data);
            b = src_pick(op_sel[2*i + 1], i, regs, op_res, consts, in_data);
            if (i < P_END)       op_res[i] = a + b;
            else if (i < M_END)  op_res[i] = a - b;
            else if (i < MU_END) op_res[i] = a * b;
            else if (i < L_END)  op_res[i] = W'(a < b);
            else                 op_res[i] = W'(a == b);
        end
    end

    // Candidate next value for every register plus the next PC
    always_comb begin
        for (int r = 0; r < NREG; r++)
            reg_val[r] = src_pick(reg_sel[r], NOP, regs, op_res, consts, in_data);
        if (reg_we[PC_IDX])
            pc_next = reg_val[PC_IDX][PW-1:0];
        else if (halt)
            pc_next = pc_cur;
        else
            pc_next = pc_cur + 1'b1;
    end

    // Program RAM is only writable while the core is not running
    always_ff @(posedge clk) begin
        if (prog_we && state != RUN) prog_ram[prog_addr] <= prog_data;
    end

    // Run control, register commit, constant loads and the output handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            regs      <= '0;
            consts    <= '0;
            out2      <= '0;
            out_valid <= 1'b0;
`ifdef CPUC_PERF_EN
            run_cycles   <= '0;
            stall_cycles <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (const_we && int'(const_addr) < NCONST) consts[const_addr] <= const_data;
                    if (start) begin
                        regs         <= '0;
                        regs[PC_IDX] <= W'(start_pc);
                        state        <= RUN;
`ifdef CPUC_PERF_EN
                        run_cycles   <= '0;
                        stall_cycles <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!stall) begin
                        for (int r = 0; r < NREG; r++)
                            if (reg_we[r] && r != PC_IDX) regs[r] <= reg_val[r];
                        regs[PC_IDX] <= W'(pc_next);
                        if (reg_we[OUT_IDX]) begin
                            out2      <= reg_val[OUT_IDX];
                            out_valid <= 1'b1;
                        end
                        if (halt) state <= DONE;
                    end
`ifdef CPUC_PERF_EN
                    if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
                    if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpuc_xbar_core.sv
// Scoreboard bench for cpuc_xbar_core: expected out2 values and expected
// (pc, out1) at each halt are queued by the stimulus; monitors pop and compare
// when out_valid pulses or done rises. Directed checks cover stalls and resets.
module tb_cpuc_xbar_core;

    localparam int W  = 16;
    localparam int PW = 6;
    localparam int IW = 61;

    typedef struct {
        logic [PW-1:0] pc;
        logic [W-1:0]  out1;
    } done_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          const_we;
    logic [1:0]    const_addr;
    logic [W-1:0]  const_data;
    logic          start;
    logic [PW-1:0] start_pc;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out1;
    logic [W-1:0]  out2;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [PW-1:0] pc;
`ifdef CPUC_PERF_EN
    logic [31:0]   run_cycles;
    logic [31:0]   stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] out_q[$];
    done_exp_t    done_q[$];
    logic         done_prev = 1'b0;

    cpuc_xbar_core dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .const_we   (const_we),
        .const_addr (const_addr),
        .const_data (const_data),
        .start      (start),
        .start_pc   (start_pc),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1       (out1),
        .out2       (out2),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .pc         (pc)
`ifdef CPUC_PERF_EN
        ,
        .run_cycles   (run_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadProg(input int addr, input logic [IW-1:0] word);
        prog_we   = 1'b1;
        prog_addr = addr[PW-1:0];
        prog_data = word;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic loadConst(input int idx, input logic [W-1:0] value);
        const_we   = 1'b1;
        const_addr = idx[1:0];
        const_data = value;
        tick();
        const_we   = 1'b0;
    endtask

    task automatic applyStimulus(input int spc);
        start    = 1'b1;
        start_pc = spc[PW-1:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=%0d expected=1", done);
        end
    endtask

    function automatic logic [IW-1:0] set_reg(input logic [IW-1:0] w, input int r, input int sel);
        logic [IW-1:0] v;
        logic [3:0]    s;
        v = w;
        s = sel[3:0];
        v[1 + r*5 +: 4] = s;
        v[1 + r*5 + 4]  = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] set_op(input logic [IW-1:0] w, input int k, input int sel);
        logic [IW-1:0] v;
        logic [3:0]    s;
        v = w;
        s = sel[3:0];
        v[21 + k*4 +: 4] = s;
        return v;
    endfunction

    // Scoreboard monitor: out_valid pops an out2 value, a rising done pops a halt record
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        done_exp_t    exp_d;
        if (out_valid) begin
            if (out_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL out2_unexpected actual=%0h expected=none", out2);
            end else begin
                exp_v = out_q.pop_front();
                checkOutput("out2_scoreboard", out2, exp_v);
            end
        end
        if (done && !done_prev) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL done_unexpected actual=pc%0h expected=none", pc);
            end else begin
                exp_d = done_q.pop_front();
                checkOutput("halt_pc", pc, exp_d.pc);
                checkOutput("halt_out1", out1, exp_d.out1);
            end
        end
        done_prev = done;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [IW-1:0] w;
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        const_we = 1'b0; const_addr = '0; const_data = '0;
        start = 1'b0; start_pc = '0; in_data = '0; in_valid = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_out1", out1, 0);
        checkOutput("rst_out2", out2, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();

        // program image
        w = '0; w[0] = 1'b1; w = set_op(w, 0, 9); w = set_op(w, 1, 10);
        w = set_reg(w, 1, 4); w = set_reg(w, 2, 4); w = set_reg(w, 3, 4);
        loadProg(0, w);
        w = '0; w = set_reg(w, 1, 13);                            loadProg(5, w);
        w = '0; w[0] = 1'b1;                                      loadProg(6, w);
        w = '0; w = set_reg(w, 1, 10);                            loadProg(63, w);
        w = '0; w = set_op(w, 4, 9); w = set_op(w, 5, 9);
        w = set_op(w, 6, 10); w = set_op(w, 7, 11); w = set_op(w, 8, 10); w = set_op(w, 9, 11);
        w = set_reg(w, 1, 6); w = set_reg(w, 2, 7); w = set_reg(w, 3, 8);
        loadProg(10, w);
        w = '0; w[0] = 1'b1; w = set_op(w, 2, 10); w = set_op(w, 3, 11);
        w = set_reg(w, 1, 5); w = set_reg(w, 3, 2);
        loadProg(11, w);
        w = '0; w = set_reg(w, 3, 12);                            loadProg(20, w);
        w = '0; w[0] = 1'b1; w = set_op(w, 0, 4); w = set_op(w, 1, 11);
        w = set_op(w, 2, 4); w = set_op(w, 3, 10); w = set_reg(w, 1, 5);
        loadProg(21, w);
        w = '0; w = set_reg(w, 0, 9);                             loadProg(22, w);
        w = '0; w = set_op(w, 0, 9); w = set_op(w, 1, 10);
        w = set_reg(w, 1, 4); w = set_reg(w, 2, 4);
        loadProg(40, w);
        w = '0; w = set_reg(w, 0, 0);                             loadProg(41, w);
        w = '0; w[0] = 1'b1; w = set_reg(w, 1, 10);               loadProg(50, w);

        // 1: plus of two constants, halt on first instruction
        loadConst(0, 16'd3);
        loadConst(1, 16'd5);
        out_q.push_back(16'd8);
        done_q.push_back('{pc: 6'd0, out1: 16'd8});
        applyStimulus(0);
        checkOutput("t1_busy", busy, 1);
        waitDone(20);

        // 2: input stall then accept
        done_q.push_back('{pc: 6'd6, out1: 16'h1234});
        applyStimulus(5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_in_ready", in_ready, 1);
            checkOutput("t2_pc_held", pc, 5);
            checkOutput("t2_out1_held", out1, 0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("t2_out1", out1, 16'h1234);
        checkOutput("t2_pc", pc, 6);
        checkOutput("t2_in_ready_off", in_ready, 0);
        waitDone(20);

        // 3: PC wraps from the last program word to zero
        out_q.push_back(16'd8);
        done_q.push_back('{pc: 6'd0, out1: 16'd8});
        applyStimulus(63);
        checkOutput("t3_pc_start", pc, 63);
        tick();
        checkOutput("t3_pc_wrap", pc, 0);
        checkOutput("t3_out1", out1, 5);
        checkOutput("t3_busy", busy, 1);
        waitDone(20);

        // 4: mul truncation, les, equ, then unsigned minus wrap
        loadConst(0, 16'h0100);
        loadConst(1, 16'd3);
        loadConst(2, 16'd5);
        out_q.push_back(16'd0);
        out_q.push_back(16'd1);
        done_q.push_back('{pc: 6'd11, out1: 16'hFFFE});
        applyStimulus(10);
        tick();
        checkOutput("t4_mul_trunc", out1, 0);
        checkOutput("t4_pc", pc, 11);
        waitDone(20);

        // 5: out_valid pulse width, then operator chaining and self-reference
        loadConst(3, 16'd7);
        out_q.push_back(16'd7);
        done_q.push_back('{pc: 6'd21, out1: 16'd2});
        applyStimulus(20);
        tick();
        checkOutput("t5_out_valid_hi", out_valid, 1);
        checkOutput("t5_out2", out2, 7);
        tick();
        checkOutput("t5_out_valid_lo", out_valid, 0);
        checkOutput("t5_out2_hold", out2, 7);
        waitDone(20);

        // 5b: explicit PC write is taken modulo the program depth
        out_q.push_back(16'h0103);
        done_q.push_back('{pc: 6'd0, out1: 16'h0103});
        applyStimulus(22);
        tick();
        checkOutput("t5b_pc_mod", pc, 0);
        waitDone(20);

        // 6: writes/start ignored in RUN, reset aborts immediately
        loadConst(0, 16'd3);
        loadConst(1, 16'd5);
        applyStimulus(40);
        tick();
        checkOutput("t6_out1", out1, 8);
        tick();
        checkOutput("t6_spin_pc", pc, 41);
        w = '0; w[0] = 1'b1; w = set_reg(w, 3, 9);
        prog_we = 1'b1; prog_addr = 6'd50; prog_data = w;
        start = 1'b1; start_pc = 6'd0;
        tick();
        prog_we = 1'b0; start = 1'b0;
        checkOutput("t6_start_ignored_pc", pc, 41);
        checkOutput("t6_start_ignored_busy", busy, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_out1", out1, 0);
        checkOutput("t6_rst_out2", out2, 0);
        checkOutput("t6_rst_pc", pc, 0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("t6_idle_done", done, 0);
        loadConst(1, 16'd5);
        done_q.push_back('{pc: 6'd50, out1: 16'd5});
        applyStimulus(50);
        waitDone(20);

        repeat (3) tick();
        checkOutput("out_q_drained", out_q.size(), 0);
        checkOutput("done_q_drained", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
